i2si_rx_fifo: RTL and testbench

I2SI_RX_FIFO -- requirements
Module: i2si_rx_fifo

---
 rtl/i2si_rx_fifo.sv | 72 +++++++
 tb/tb_i2si_rx_fifo.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/i2si_rx_fifo.sv
// i2si_rx_fifo: receive-sample FIFO between the I2S-in stage and its consumer.
// Define I2SI_RX_FIFO_AFULL_EN to add the registered fifo_afull output.
module i2si_rx_fifo #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          i2si_in_data,
  input  logic                       i2si_in_xfc,
  input  logic                       rf_fifo_clr,
  input  logic                       rf_ovf_clr,
  input  logic                       rd_req,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic                       fifo_empty,
  output logic                       fifo_full,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       ovf_sticky
`ifdef I2SI_RX_FIFO_AFULL_EN
  ,
  output logic                       fifo_afull
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic rd_acc, wr_acc, drop;
  logic [LW-1:0] level_nxt;
  assign fifo_empty = fifo_level == '0;
  assign fifo_full  = fifo_level == LW'(DEPTH);
  // A full FIFO still takes a write when a read frees the head slot in the same cycle.
  always_comb begin
    rd_acc    = rd_req && !fifo_empty;
    wr_acc    = i2si_in_xfc && (!fifo_full || rd_acc);
    drop      = i2si_in_xfc && !wr_acc;
    level_nxt = rf_fifo_clr ? '0 : fifo_level + LW'(wr_acc) - LW'(rd_acc);
  end
  always_ff @(posedge clk)
    if (wr_acc && !rf_fifo_clr) mem[wptr] <= i2si_in_data;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      fifo_level <= level_nxt;
      rd_valid   <= rd_acc && !rf_fifo_clr;
      ovf_sticky <= drop ? 1'b1 : rf_ovf_clr ? 1'b0 : ovf_sticky;
      if (rf_fifo_clr) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (wr_acc) wptr <= wptr + 1'b1;
        if (rd_acc) begin
          rptr    <= rptr + 1'b1;
          rd_data <= mem[rptr];
        end
      end
    end
  end
`ifdef I2SI_RX_FIFO_AFULL_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) fifo_afull <= 1'b0;
    else fifo_afull <= level_nxt >= LW'(AF_THRESH);
`endif
endmodule

// File: tb/tb_i2si_rx_fifo.sv
// tb_i2si_rx_fifo: directed self-checking bench for i2si_rx_fifo (DATA_W=32, DEPTH=8, AF_THRESH=6).
module tb_i2si_rx_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] i2si_in_data = '0;
  logic i2si_in_xfc = 1'b0, rf_fifo_clr = 1'b0, rf_ovf_clr = 1'b0, rd_req = 1'b0;
  logic [31:0] rd_data;
  logic rd_valid, fifo_empty, fifo_full, ovf_sticky;
  logic [3:0] fifo_level;
`ifdef I2SI_RX_FIFO_AFULL_EN
  logic fifo_afull;
`endif
  int n_cmp = 0;
  int n_err = 0;

  i2si_rx_fifo #(.DATA_W(32), .DEPTH(8), .AF_THRESH(6)) dut (
    .clk(clk), .rst(rst), .i2si_in_data(i2si_in_data), .i2si_in_xfc(i2si_in_xfc),
    .rf_fifo_clr(rf_fifo_clr), .rf_ovf_clr(rf_ovf_clr), .rd_req(rd_req),
    .rd_data(rd_data), .rd_valid(rd_valid), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .fifo_level(fifo_level), .ovf_sticky(ovf_sticky)
`ifdef I2SI_RX_FIFO_AFULL_EN
    , .fifo_afull(fifo_afull)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_empty", 32'(fifo_empty), 1);
    chk("rst_full", 32'(fifo_full), 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_ovf", 32'(ovf_sticky), 0);
`ifdef I2SI_RX_FIFO_AFULL_EN
    chk("rst_afull", 32'(fifo_afull), 0);
`endif
    cyc();
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      i2si_in_xfc = 1'b1;
      i2si_in_data = 32'h10 + 32'(i);
      cyc();
      chk("fill_level", 32'(fifo_level), 32'(i + 1));
`ifdef I2SI_RX_FIFO_AFULL_EN
      chk("fill_afull", 32'(fifo_afull), (i + 1 >= 6) ? 1 : 0);
`endif
    end
    i2si_in_xfc = 1'b0;
    chk("fill_full", 32'(fifo_full), 1);
    chk("fill_ovf", 32'(ovf_sticky), 0);
    chk("fill_empty", 32'(fifo_empty), 0);
    i2si_in_xfc = 1'b1;
    i2si_in_data = 32'hDEAD;
    cyc();
    i2si_in_xfc = 1'b0;
    chk("ovf_set", 32'(ovf_sticky), 1);
    chk("ovf_level", 32'(fifo_level), 8);
    rf_ovf_clr = 1'b1;
    cyc();
    rf_ovf_clr = 1'b0;
    chk("ovf_clr", 32'(ovf_sticky), 0);
    for (int i = 0; i < 8; i++) begin
      rd_req = 1'b1;
      cyc();
      rd_req = 1'b0;
      chk("drain_valid", 32'(rd_valid), 1);
      chk("drain_data", rd_data, 32'h10 + 32'(i));
      chk("drain_level", 32'(fifo_level), 32'(7 - i));
      cyc();
      chk("drain_valid_low", 32'(rd_valid), 0);
      chk("drain_hold", rd_data, 32'h10 + 32'(i));
    end
    rd_req = 1'b1;
    cyc();
    rd_req = 1'b0;
    chk("empty_rd_valid", 32'(rd_valid), 0);
    chk("empty_rd_data", rd_data, 32'h17);
    chk("empty_flag", 32'(fifo_empty), 1);
    for (int i = 0; i < 8; i++) begin
      i2si_in_xfc = 1'b1;
      i2si_in_data = 32'h20 + 32'(i);
      cyc();
    end
    chk("refill_full", 32'(fifo_full), 1);
    i2si_in_data = 32'hAA;
    rd_req = 1'b1;
    cyc();
    i2si_in_xfc = 1'b0;
    chk("sim_valid", 32'(rd_valid), 1);
    chk("sim_data", rd_data, 32'h20);
    chk("sim_level", 32'(fifo_level), 8);
    chk("sim_ovf", 32'(ovf_sticky), 0);
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("sim_drain", rd_data, (i < 7) ? 32'h21 + 32'(i) : 32'hAA);
    end
    rd_req = 1'b0;
    chk("sim_empty", 32'(fifo_empty), 1);
    for (int i = 0; i < 3; i++) begin
      i2si_in_xfc = 1'b1;
      i2si_in_data = 32'h30 + 32'(i);
      cyc();
    end
    chk("flush_pre_level", 32'(fifo_level), 3);
    rf_fifo_clr = 1'b1;
    rd_req = 1'b1;
    i2si_in_data = 32'h99;
    cyc();
    rf_fifo_clr = 1'b0;
    rd_req = 1'b0;
    i2si_in_xfc = 1'b0;
    chk("flush_level", 32'(fifo_level), 0);
    chk("flush_empty", 32'(fifo_empty), 1);
    chk("flush_rd_valid", 32'(rd_valid), 0);
    chk("flush_rd_data", rd_data, 32'hAA);
    for (int i = 0; i < 5; i++) begin
      i2si_in_xfc = 1'b1;
      i2si_in_data = 32'h40 + 32'(i);
      cyc();
    end
    i2si_in_xfc = 1'b0;
    chk("mid_pre_level", 32'(fifo_level), 5);
    rd_req = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_level", 32'(fifo_level), 0);
    chk("mid_rd_data", rd_data, 0);
    chk("mid_ovf", 32'(ovf_sticky), 0);
    chk("mid_empty", 32'(fifo_empty), 1);
    cyc();
    chk("mid_rd_valid", 32'(rd_valid), 0);
    rd_req = 1'b0;
    rst = 1'b0;
    i2si_in_xfc = 1'b1;
    i2si_in_data = 32'h55;
    cyc();
    i2si_in_xfc = 1'b0;
    chk("post_level", 32'(fifo_level), 1);
    rd_req = 1'b1;
    cyc();
    rd_req = 1'b0;
    chk("post_valid", 32'(rd_valid), 1);
    chk("post_data", rd_data, 32'h55);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
